// File: rtl/mrfm_pkg.sv
// Shared definitions for the MRFM RX framer: FSM states, settings-register
// field layout, header field widths and the channel-count clamp.
package mrfm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int unsigned CNT_LSB   = 0;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned EN_BIT    = 4;
  localparam int unsigned CFG_W     = EN_BIT + 1;

  localparam int unsigned HDR_LEN_W = 4;

  // A request of 0 or more than the physical channel count means "all".
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req,
                                                   input int unsigned nchan);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(nchan);
    if (req == '0 || req > lim) return lim;
    return req;
  endfunction

endpackage

// File: rtl/setting_reg.sv
// Settings-bus register: captures the low WIDTH bits of serial data when the
// strobe hits the configured address.
module setting_reg #(
  parameter logic [6:0]  ADDR     = 7'd0,
  parameter int unsigned WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic [6:0]       addr,
  input  logic [31:0]      in,
  output logic [WIDTH-1:0] out
);

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^in[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= AT_RESET;
    end else if (strobe && addr == ADDR) begin
      out <= in[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mrfm_rx_framer.sv
// Captures NCHAN strobed samples and serialises the active subset to a
// valid/ready sink. Optional per-frame header word: MRFM_FRAME_HEADER_EN.
module mrfm_rx_framer
  import mrfm_pkg::*;
#(
  parameter int unsigned NCHAN   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter logic [6:0]  SR_ADDR = 7'd40
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [6:0]             serial_addr,
  input  logic [31:0]            serial_data,
  input  logic                   serial_strobe,
  input  logic                   in_strobe,
  input  logic [NCHAN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  input  logic                   clear_status,
  output logic                   overrun,
  output logic [3:0]             numchan
);

  localparam logic [CFG_W-1:0] CFG_RST = {1'b0, 4'(NCHAN)};

  logic [CFG_W-1:0] w_cfg;
  logic [3:0]       w_numchan;
  logic             w_enable;

  setting_reg #(
    .ADDR    (SR_ADDR),
    .WIDTH   (CFG_W),
    .AT_RESET(CFG_RST)
  ) u_sr (
    .clk   (clock),
    .rst_n (reset_n),
    .strobe(serial_strobe),
    .addr  (serial_addr),
    .in    (serial_data),
    .out   (w_cfg)
  );

  assign w_numchan = clamp_count(w_cfg[CNT_LSB +: CNT_W], NCHAN);
  assign w_enable  = w_cfg[EN_BIT];
  assign numchan   = w_numchan;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold [NCHAN];
  logic [3:0]       r_len;
  logic [3:0]       r_idx;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_overrun;

  logic             w_hs;
  logic             w_done;
  logic             w_capture;
  logic             w_drop;
  logic [3:0]       w_idx_nxt;
  logic [WIDTH-1:0] w_next_word;

  assign w_hs      = r_out_valid & out_ready;
  assign w_done    = w_hs & r_out_last & (r_state == ST_SEND);
  // A strobe landing on the final handshake starts the next frame directly.
  assign w_capture = in_strobe & w_enable & ((r_state == ST_IDLE) | w_done);
  assign w_drop    = in_strobe & (r_state != ST_IDLE) & ~w_done;
  assign w_idx_nxt = r_idx + 4'd1;

  always_comb begin
    w_next_word = '0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      if (w_idx_nxt == 4'(k)) w_next_word = r_hold[k];
    end
  end

`ifdef MRFM_FRAME_HEADER_EN
  localparam int unsigned FC_W = WIDTH - HDR_LEN_W;
  logic [FC_W-1:0] r_frame_cnt;
  logic [FC_W-1:0] w_frame_cnt_nxt;
  assign w_frame_cnt_nxt = w_done ? r_frame_cnt + FC_W'(1) : r_frame_cnt;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overrun   <= 1'b0;
      for (int unsigned k = 0; k < NCHAN; k++) r_hold[k] <= '0;
`ifdef MRFM_FRAME_HEADER_EN
      r_frame_cnt <= '0;
`endif
    end else begin
      r_overrun <= w_drop | (r_overrun & ~clear_status);
`ifdef MRFM_FRAME_HEADER_EN
      r_frame_cnt <= w_frame_cnt_nxt;
`endif
      if (w_capture) begin
        for (int unsigned k = 0; k < NCHAN; k++) r_hold[k] <= in_data[k*WIDTH +: WIDTH];
        r_len       <= w_numchan;
        r_idx       <= '0;
        r_out_valid <= 1'b1;
`ifdef MRFM_FRAME_HEADER_EN
        r_state     <= ST_HDR;
        r_out_data  <= {w_frame_cnt_nxt, w_numchan};
        r_out_last  <= 1'b0;
`else
        r_state     <= ST_SEND;
        r_out_data  <= in_data[WIDTH-1:0];
        r_out_last  <= (w_numchan == 4'd1);
`endif
      end else begin
        case (r_state)
`ifdef MRFM_FRAME_HEADER_EN
          ST_HDR: begin
            if (w_hs) begin
              r_state    <= ST_SEND;
              r_out_data <= r_hold[0];
              r_out_last <= (r_len == 4'd1);
            end
          end
`endif
          ST_SEND: begin
            if (w_hs) begin
              if (r_out_last) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
              end else begin
                r_idx      <= w_idx_nxt;
                r_out_data <= w_next_word;
                r_out_last <= (w_idx_nxt == r_len - 4'd1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_mrfm_rx_framer.sv
// Directed self-checking bench for mrfm_rx_framer (NCHAN=4, WIDTH=16).
module tb_mrfm_rx_framer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        in_strobe;
  logic [63:0] in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        clear_status;
  logic        overrun;
  logic [3:0]  numchan;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] DATA_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] DATA_B = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
  localparam logic [63:0] DATA_X = {16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hBBBB};

  mrfm_rx_framer #(.NCHAN(4), .WIDTH(16), .SR_ADDR(7'd40)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .in_strobe    (in_strobe),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .clear_status (clear_status),
    .overrun      (overrun),
    .numchan      (numchan)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_cfg(input logic [31:0] val);
    serial_addr   = 7'd40;
    serial_data   = val;
    serial_strobe = 1'b1;
    step();
    serial_strobe = 1'b0;
    serial_addr   = 7'd0;
  endtask

  task automatic strobe_frame(input logic [63:0] d);
    in_data   = d;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && out_valid; c++) step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; serial_addr = '0; serial_data = '0; serial_strobe = 1'b0;
    in_strobe = 1'b0; in_data = '0; out_ready = 1'b0; clear_status = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", out_last); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", out_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b want=0", overrun); end
    total++; if (numchan !== 4'd4) begin bad++; $display("FAIL rst_numchan got=%0d want=4", numchan); end
    // enable resets to 0: strobe ignored
    strobe_frame(DATA_A);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_disabled_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_basic();
    write_cfg(32'h14);
    out_ready = 1'b1;
    strobe_frame(DATA_A);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(k + 1) || out_last !== (k == 3)) begin
        bad++;
        $display("FAIL basic_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, out_valid, out_data, out_last, 16'(k + 1), (k == 3));
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_count();
    write_cfg(32'h12);
    total++; if (numchan !== 4'd2) begin bad++; $display("FAIL count2_numchan got=%0d want=2", numchan); end
    out_ready = 1'b1;
    strobe_frame(DATA_A);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(k + 1) || out_last !== (k == 1)) begin
        bad++;
        $display("FAIL count2_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, out_valid, out_data, out_last, 16'(k + 1), (k == 1));
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL count2_end got=%b want=0", out_valid); end
    write_cfg(32'h10);
    total++; if (numchan !== 4'd4) begin bad++; $display("FAIL count0_clamp got=%0d want=4", numchan); end
    write_cfg(32'h19);
    total++; if (numchan !== 4'd4) begin bad++; $display("FAIL count9_clamp got=%0d want=4", numchan); end
    write_cfg(32'h14);
  endtask

  task automatic test_backpressure();
    int e;
    logic rdy;
    out_ready = 1'b0;
    strobe_frame(DATA_A);
    e = 0;
    for (int c = 0; c < 20 && e < 4; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(e + 1) || out_last !== (e == 3)) begin
        bad++;
        $display("FAIL bp_cycle%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 c, out_valid, out_data, out_last, 16'(e + 1), (e == 3));
      end
      in_strobe = (c == 2);
      if (c == 2) in_data = DATA_X;
      rdy = ~c[0];
      out_ready = rdy;
      step();
      if (rdy) e++;
    end
    in_strobe = 1'b0;
    total++; if (e != 4) begin bad++; $display("FAIL bp_timeout words=%0d want=4", e); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
    clear_status = 1'b1; step(); clear_status = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b want=0", overrun); end
    // set and clear in the same cycle: set wins
    out_ready = 1'b1;
    strobe_frame(DATA_A);
    in_strobe = 1'b1; clear_status = 1'b1; in_data = DATA_X;
    step();
    in_strobe = 1'b0; clear_status = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_set_wins got=%b want=1", overrun); end
    drain();
    clear_status = 1'b1; step(); clear_status = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_clear2 got=%b want=0", overrun); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    strobe_frame(DATA_A);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin in_data = DATA_B; in_strobe = 1'b1; end
      step();
    end
    in_strobe = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0005 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got v=%b d=%h l=%b want v=1 d=0005 l=0", out_valid, out_data, out_last);
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    step(); step(); step();
    total++;
    if (out_data !== 16'h0008 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL b2b_last got d=%h l=%b want d=0008 l=1", out_data, out_last);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    strobe_frame(DATA_A);
    step();
    reset_n = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    total++; if (numchan !== 4'd4) begin bad++; $display("FAIL rmid_numchan got=%0d want=4", numchan); end
    reset_n = 1'b1;
    write_cfg(32'h02);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    total++; if (numchan !== 4'd4) begin bad++; $display("FAIL rmid_cfg_reset got=%0d want=4", numchan); end
    strobe_frame(DATA_A);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_disabled got=%b want=0", out_valid); end
    write_cfg(32'h14);
    strobe_frame(DATA_B);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0005) begin
      bad++;
      $display("FAIL rmid_reenable got v=%b d=%h want v=1 d=0005", out_valid, out_data);
    end
    drain();
  endtask

`ifdef MRFM_FRAME_HEADER_EN
  task automatic test_header();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0003; exp_w[1] = 16'h0001; exp_w[2] = 16'h0002; exp_w[3] = 16'h0003;
    write_cfg(32'h13);
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp_w[0] = (f == 0) ? 16'h0003 : 16'h0013;
      strobe_frame(DATA_A);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_last !== (k == 3)) begin
          bad++;
          $display("FAIL hdr_f%0d_w%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   f, k, out_valid, out_data, out_last, exp_w[k], (k == 3));
        end
        step();
      end
    end
    write_cfg(32'h11);
    for (int f = 2; f < 4095; f++) begin
      strobe_frame(DATA_A); step(); step();
    end
    strobe_frame(DATA_A);
    total++; if (out_data !== 16'hFFF1) begin bad++; $display("FAIL hdr_max got=%h want=fff1", out_data); end
    step(); step();
    strobe_frame(DATA_A);
    total++; if (out_data !== 16'h0001) begin bad++; $display("FAIL hdr_wrap got=%h want=0001", out_data); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
`ifdef MRFM_FRAME_HEADER_EN
    test_header();
`else
    test_basic();
    test_count();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
